// File: rtl/hrm_io_pkg.sv
// Shared definitions for the HRM I/O controller: byte width, OUTBOX drain
// state encoding and the INBOX grant decision helper.
package hrm_io_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } out_state_t;

    // Returns 1 when source A should own the INBOX this cycle. With only one
    // source valid that source wins; with both valid, fixed priority picks A,
    // otherwise A wins when B was the last source served.
    function automatic logic pick_a(input logic prio_a,
                                    input logic a_valid,
                                    input logic b_valid,
                                    input logic last_b);
        logic sel;
        if (a_valid && !b_valid) begin
            sel = 1'b1;
        end else if (!a_valid) begin
            sel = 1'b0;
        end else begin
            sel = prio_a | last_b;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hrm_in_arb.sv
// INBOX arbiter: picks between the host-loader (A) and UART-RX (B) byte
// sources, registers the accepted byte and pulses the INBOX write. A write is
// never issued on two consecutive cycles so the FIFO full flag can settle.
module hrm_in_arb
    import hrm_io_pkg::*;
#(
    parameter int PRIO_A = 0
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              a_valid,
    input  logic [BYTE_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [BYTE_W-1:0] b_data,
    output logic              b_ready,
    output logic [BYTE_W-1:0] cpu_in_data,
    output logic              cpu_in_wr,
    input  logic              cpu_in_full
);

    logic live_r;     // low in the first cycle after reset release
    logic last_b_r;   // 1 when B was granted last (reset value)
    logic pick_a_s;
    logic elig_s;
    logic a_take_s;
    logic b_take_s;

    // Grant the INBOX to one valid source when a write slot is available
    always_comb begin
        pick_a_s = pick_a((PRIO_A != 0), a_valid, b_valid, last_b_r);
        elig_s   = live_r && !cpu_in_full && !cpu_in_wr;
        if (elig_s) begin
            a_ready = a_valid && pick_a_s;
            b_ready = b_valid && !pick_a_s;
        end else begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end
    end

    assign a_take_s = a_valid && a_ready;
    assign b_take_s = b_valid && b_ready;

    // Capture the accepted byte, pulse the write and remember who was served
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            live_r      <= 1'b0;
            last_b_r    <= 1'b1;
            cpu_in_wr   <= 1'b0;
            cpu_in_data <= {BYTE_W{1'b0}};
        end else begin
            live_r <= 1'b1;
            if (a_take_s) begin
                cpu_in_data <= a_data;
                cpu_in_wr   <= 1'b1;
                last_b_r    <= 1'b0;
            end else if (b_take_s) begin
                cpu_in_data <= b_data;
                cpu_in_wr   <= 1'b1;
                last_b_r    <= 1'b1;
            end else begin
                cpu_in_wr   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hrm_io_ctrl.sv
// HRM I/O controller top: INBOX arbitration (hrm_in_arb) and the OUTBOX drain
// sequencer feeding the downstream byte sink. The two paths are independent.
// Optional build macro HRM_IO_STATS_EN adds 16-bit wrapping write/pop counters.
module hrm_io_ctrl
    import hrm_io_pkg::*;
#(
    parameter int PRIO_A = 0
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              a_valid,
    input  logic [BYTE_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [BYTE_W-1:0] b_data,
    output logic              b_ready,
    output logic [BYTE_W-1:0] cpu_in_data,
    output logic              cpu_in_wr,
    input  logic              cpu_in_full,
    input  logic [BYTE_W-1:0] cpu_out_data,
    input  logic              cpu_out_empty,
    output logic              cpu_out_rd,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
`ifdef HRM_IO_STATS_EN
    output logic [15:0]       in_count,
    output logic [15:0]       out_count,
`endif
    input  logic              tx_ready
);

    out_state_t state_r;

    hrm_in_arb #(
        .PRIO_A (PRIO_A)
    ) u_in_arb (
        .clk         (clk),
        .i_rst       (i_rst),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .cpu_in_data (cpu_in_data),
        .cpu_in_wr   (cpu_in_wr),
        .cpu_in_full (cpu_in_full)
    );

    // OUTBOX drain: pop one byte, present it until taken, then rest one cycle
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r    <= ST_IDLE;
            cpu_out_rd <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= {BYTE_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!cpu_out_empty) begin
                        state_r    <= ST_POP;
                        cpu_out_rd <= 1'b1;
                    end
                end
                ST_POP: begin
                    // Show-ahead head is still valid while the pop is in flight
                    tx_data    <= cpu_out_data;
                    tx_valid   <= 1'b1;
                    cpu_out_rd <= 1'b0;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state_r  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cpu_out_rd <= 1'b0;
                    tx_valid   <= 1'b0;
                end
            endcase
        end
    end

`ifdef HRM_IO_STATS_EN
    // Count INBOX writes and OUTBOX pops, wrapping at 16 bits
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            in_count  <= 16'd0;
            out_count <= 16'd0;
        end else begin
            if (cpu_in_wr) begin
                in_count <= in_count + 16'd1;
            end
            if (cpu_out_rd) begin
                out_count <= out_count + 16'd1;
            end
        end
    end
`endif

endmodule
